wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 23 ++
 rtl/wb_load_ext.sv | 24 ++
 rtl/wb_stage.sv | 152 +++++++++++++++
 tb/tb_wb_stage.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared widths, constants and types for the write-back stage.
// Shared by wb_stage and wb_load_ext.
package wb_stage_pkg;
   localparam int REG_BUS = 64;
   localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
   localparam int WB_FIFO_DEPTH = 2;
   localparam int WB_STARVE_LIMIT = 4;
   localparam logic [1:0] LSU_SIZE_B = 2'd0;
   localparam logic [1:0] LSU_SIZE_H = 2'd1;
   localparam logic [1:0] LSU_SIZE_W = 2'd2;
   localparam logic [1:0] LSU_SIZE_D = 2'd3;

   typedef struct packed {
      logic [4:0]         rd;
      logic [REG_BUS-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_ALU,
      SEL_LSU
   } wb_sel_t;
endpackage

// File: rtl/wb_load_ext.sv
// Combinational load-data extraction: selects the addressed byte/half/word/dword
// from an aligned doubleword and sign- or zero-extends it to the register width.
module wb_load_ext
   import wb_stage_pkg::*;
(
   input  logic [REG_BUS-1:0] data,
   input  logic [2:0]         off,
   input  logic [1:0]         size,
   input  logic               zext,
   output logic [REG_BUS-1:0] ext
);
   logic [REG_BUS-1:0] shifted;

   always_comb begin
      // A full doubleword is always aligned, so its offset is ignored.
      shifted = (size == LSU_SIZE_D) ? data : (data >> {off, 3'b000});
      case (size)
         LSU_SIZE_B: ext = {{56{!zext && shifted[7]}},  shifted[7:0]};
         LSU_SIZE_H: ext = {{48{!zext && shifted[15]}}, shifted[15:0]};
         LSU_SIZE_W: ext = {{32{!zext && shifted[31]}}, shifted[31:0]};
         default:    ext = shifted;
      endcase
   end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: arbitrates single-cycle ALU results against a 2-entry load
// buffer with starvation protection. Define WB_FWD_EN to expose fwd_* bypass ports.
module wb_stage
   import wb_stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               alu_valid,
   output logic               alu_ready,
   input  logic [4:0]         alu_rd,
   input  logic               alu_wen,
   input  logic [REG_BUS-1:0] alu_data,
   input  logic               lsu_valid,
   output logic               lsu_ready,
   input  logic [4:0]         lsu_rd,
   input  logic [REG_BUS-1:0] lsu_data,
   input  logic [2:0]         lsu_off,
   input  logic [1:0]         lsu_size,
   input  logic               lsu_unsigned,
   output logic               w_ena,
   output logic [4:0]         w_addr,
   output logic [REG_BUS-1:0] w_data
`ifdef WB_FWD_EN
   ,
   output logic               fwd_valid,
   output logic [4:0]         fwd_addr,
   output logic [REG_BUS-1:0] fwd_data
`endif
);
   wb_entry_t          fifo_reg  [WB_FIFO_DEPTH];
   wb_entry_t          fifo_next [WB_FIFO_DEPTH];
   logic [1:0]         count_reg, count_next;
   logic [2:0]         age_reg, age_next;
   logic               w_ena_reg;
   logic [4:0]         w_addr_reg;
   logic [REG_BUS-1:0] w_data_reg;

   logic [REG_BUS-1:0] ext_data;
   logic               head_valid, starve, alu_cand, push, pop, wr_slot;
   wb_sel_t            sel;
   logic               sel_valid;
   logic [4:0]         sel_addr;
   logic [REG_BUS-1:0] sel_data;

   wb_load_ext u_load_ext (
      .data (lsu_data),
      .off  (lsu_off),
      .size (lsu_size),
      .zext (lsu_unsigned),
      .ext  (ext_data)
   );

   assign head_valid = (count_reg != 2'd0);
   assign starve     = head_valid && (age_reg == 3'(WB_STARVE_LIMIT));
   assign alu_cand   = alu_valid && alu_wen && (alu_rd != 5'd0);
   assign lsu_ready  = (count_reg < 2'(WB_FIFO_DEPTH));
   assign alu_ready  = !(starve && alu_valid);
   assign push       = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
   assign pop        = (sel == SEL_LSU);

   always_comb begin
      sel = SEL_NONE;
      if (starve)
         sel = SEL_LSU;
      else if (alu_cand)
         sel = SEL_ALU;
      else if (head_valid)
         sel = SEL_LSU;
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_addr  = 5'd0;
      sel_data  = ZERO_WORD;
      case (sel)
         SEL_ALU: begin
            sel_valid = 1'b1;
            sel_addr  = alu_rd;
            sel_data  = alu_data;
         end
         SEL_LSU: begin
            sel_valid = 1'b1;
            sel_addr  = fifo_reg[0].rd;
            sel_data  = fifo_reg[0].data;
         end
         default: ;
      endcase
   end

   // Slot 0 is always the head; a push never coincides with a pop from a full buffer,
   // so the free slot is 1 only when one entry stays resident.
   assign wr_slot = !pop && count_reg[0];

   always_comb begin
      for (int i = 0; i < WB_FIFO_DEPTH; i++)
         fifo_next[i] = fifo_reg[i];
      if (pop) begin
         for (int i = 0; i < WB_FIFO_DEPTH - 1; i++)
            fifo_next[i] = fifo_reg[i + 1];
         fifo_next[WB_FIFO_DEPTH - 1] = '0;
      end
      if (push)
         fifo_next[wr_slot] = '{rd: lsu_rd, data: ext_data};
   end

   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + 2'd1;
      else if (pop && !push)
         count_next = count_reg - 2'd1;
   end

   always_comb begin
      if (!head_valid || pop)
         age_next = 3'd0;
      else if (age_reg == 3'(WB_STARVE_LIMIT))
         age_next = age_reg;
      else
         age_next = age_reg + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg  <= 2'd0;
         age_reg    <= 3'd0;
         w_ena_reg  <= 1'b0;
         w_addr_reg <= 5'd0;
         w_data_reg <= ZERO_WORD;
         for (int i = 0; i < WB_FIFO_DEPTH; i++)
            fifo_reg[i] <= '0;
      end else begin
         count_reg  <= count_next;
         age_reg    <= age_next;
         w_ena_reg  <= sel_valid;
         w_addr_reg <= sel_addr;
         w_data_reg <= sel_data;
         for (int i = 0; i < WB_FIFO_DEPTH; i++)
            fifo_reg[i] <= fifo_next[i];
      end
   end

   assign w_ena  = w_ena_reg;
   assign w_addr = w_addr_reg;
   assign w_data = w_data_reg;

`ifdef WB_FWD_EN
   assign fwd_valid = sel_valid && !rst;
   assign fwd_addr  = sel_addr;
   assign fwd_data  = sel_data;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_wb_stage;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        alu_valid, alu_ready, alu_wen;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        lsu_valid, lsu_ready, lsu_unsigned;
   logic [4:0]  lsu_rd;
   logic [63:0] lsu_data;
   logic [2:0]  lsu_off;
   logic [1:0]  lsu_size;
   logic        w_ena;
   logic [4:0]  w_addr;
   logic [63:0] w_data;
`ifdef WB_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [63:0] fwd_data;
`endif

   int checks   = 0;
   int failures = 0;

   wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_ready    (alu_ready),
      .alu_rd       (alu_rd),
      .alu_wen      (alu_wen),
      .alu_data     (alu_data),
      .lsu_valid    (lsu_valid),
      .lsu_ready    (lsu_ready),
      .lsu_rd       (lsu_rd),
      .lsu_data     (lsu_data),
      .lsu_off      (lsu_off),
      .lsu_size     (lsu_size),
      .lsu_unsigned (lsu_unsigned),
      .w_ena        (w_ena),
      .w_addr       (w_addr),
      .w_data       (w_data)
`ifdef WB_FWD_EN
      ,
      .fwd_valid    (fwd_valid),
      .fwd_addr     (fwd_addr),
      .fwd_data     (fwd_data)
`endif
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } ent_t;

   ent_t        mq[$];
   int          m_wait;
   logic        m_alu_ready, m_lsu_ready, m_w_ena;
   logic [4:0]  m_w_addr;
   logic [63:0] m_w_data;

   function automatic logic [63:0] ref_ext(input logic [63:0] d, input int off,
                                           input int size, input bit uns);
      int nbits = 8 << size;
      logic [63:0] f, mask;
      f = (size == 3) ? d : (d >> (8 * off));
      if (nbits < 64) begin
         mask = (64'd1 << nbits) - 64'd1;
         f = f & mask;
         if (!uns && f[nbits-1]) f = f | ~mask;
      end
      return f;
   endfunction

   // Evaluates the current inputs against the model: sets expected readies for this
   // cycle and the write that should appear after the coming edge.
   task automatic model_step();
      ent_t e;
      bit   starve, take_head;
      int   n;
      n = mq.size();
      m_w_ena = 1'b0; m_w_addr = 5'd0; m_w_data = 64'd0;
      if (rst) begin
         mq.delete(); m_wait = 0; m_alu_ready = 1'b1; m_lsu_ready = 1'b1;
         return;
      end
      starve      = (n > 0) && (m_wait >= 4);
      m_alu_ready = !(starve && alu_valid);
      m_lsu_ready = (n < 2);
      take_head   = 0;
      if (starve) take_head = 1;
      else if (alu_valid && alu_wen && alu_rd != 0) begin
         m_w_ena = 1'b1; m_w_addr = alu_rd; m_w_data = alu_data;
      end else if (n > 0) take_head = 1;
      if (take_head) begin
         e = mq.pop_front();
         m_w_ena = 1'b1; m_w_addr = e.rd; m_w_data = e.data;
      end
      if (lsu_valid && n < 2 && lsu_rd != 0) begin
         e.rd = lsu_rd;
         e.data = ref_ext(lsu_data, int'(lsu_off), int'(lsu_size), lsu_unsigned);
         mq.push_back(e);
      end
      if (take_head || n == 0) m_wait = 0;
      else if (m_wait < 4) m_wait++;
   endtask

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 0; alu_wen = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0; lsu_off = 0; lsu_size = 0; lsu_unsigned = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      alu_valid = 1; alu_wen = 1; alu_rd = 5'd31; alu_data = 64'h55;
      tick();
      rst = 1;
      tick();
      checks++; if (w_ena !== 1'b0) begin failures++; $display("FAIL reset_w_ena got=%0h exp=0", w_ena); end
      checks++; if (w_addr !== 5'd0) begin failures++; $display("FAIL reset_w_addr got=%0h exp=0", w_addr); end
      checks++; if (w_data !== 64'd0) begin failures++; $display("FAIL reset_w_data got=%0h exp=0", w_data); end
      rst = 0;
      idle_inputs();
      #1;
      checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_alu_ready got=%0b exp=1", alu_ready); end
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL reset_lsu_ready got=%0b exp=1", lsu_ready); end
      $display("reset: w_ena=%0b lsu_ready=%0b alu_ready=%0b", w_ena, lsu_ready, alu_ready);
   endtask

   task automatic test_alu();
      do_reset();
      alu_valid = 1; alu_wen = 1; alu_rd = 5'd5; alu_data = 64'h1234;
      tick();
      $display("alu: rd=5 -> w_ena=%0b w_addr=%0d w_data=%0h", w_ena, w_addr, w_data);
      checks++; if (w_ena !== 1'b1) begin failures++; $display("FAIL alu_w_ena got=%0b exp=1", w_ena); end
      checks++; if (w_addr !== 5'd5) begin failures++; $display("FAIL alu_w_addr got=%0d exp=5", w_addr); end
      checks++; if (w_data !== 64'h1234) begin failures++; $display("FAIL alu_w_data got=%0h exp=1234", w_data); end
      alu_rd = 5'd0; alu_data = 64'hDEAD;
      tick();
      $display("alu: rd=0 -> w_ena=%0b", w_ena);
      checks++; if (w_ena !== 1'b0 || w_addr !== 5'd0 || w_data !== 64'd0) begin
         failures++; $display("FAIL alu_rd0 got=%0b/%0d/%0h exp=0/0/0", w_ena, w_addr, w_data); end
      alu_rd = 5'd6; alu_wen = 0;
      tick();
      checks++; if (w_ena !== 1'b0) begin failures++; $display("FAIL alu_nowen got=%0b exp=0", w_ena); end
      idle_inputs();
   endtask

   task automatic test_load_ext();
      logic [63:0] c_data [3];
      logic [2:0]  c_off  [3];
      logic [1:0]  c_size [3];
      logic        c_uns  [3];
      logic [63:0] c_exp  [3];
      c_data[0] = 64'h80FF_0000_0000_0000; c_off[0] = 3'd7; c_size[0] = 2'd0; c_uns[0] = 0; c_exp[0] = 64'hFFFF_FFFF_FFFF_FF80;
      c_data[1] = 64'h80FF_0000_0000_0000; c_off[1] = 3'd7; c_size[1] = 2'd0; c_uns[1] = 1; c_exp[1] = 64'h80;
      c_data[2] = 64'h80FF_0000_0000_0000; c_off[2] = 3'd4; c_size[2] = 2'd2; c_uns[2] = 0; c_exp[2] = 64'hFFFF_FFFF_80FF_0000;
      for (int i = 0; i < 3; i++) begin
         do_reset();
         lsu_valid = 1; lsu_rd = 5'(8 + i); lsu_data = c_data[i];
         lsu_off = c_off[i]; lsu_size = c_size[i]; lsu_unsigned = c_uns[i];
         tick();
         checks++; if (w_ena !== 1'b0) begin failures++; $display("FAIL ext%0d_push_w_ena got=%0b exp=0", i, w_ena); end
         idle_inputs();
         tick();
         $display("load ext case %0d: w_addr=%0d w_data=%016h", i, w_addr, w_data);
         checks++; if (w_ena !== 1'b1 || w_addr !== 5'(8 + i)) begin
            failures++; $display("FAIL ext%0d_addr got=%0b/%0d exp=1/%0d", i, w_ena, w_addr, 8 + i); end
         checks++; if (w_data !== c_exp[i]) begin
            failures++; $display("FAIL ext%0d_data got=%016h exp=%016h", i, w_data, c_exp[i]); end
      end
   endtask

   task automatic test_priority();
      do_reset();
      alu_valid = 1; alu_wen = 1; alu_rd = 5'd3; alu_data = 64'h33;
      lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 64'h44; lsu_size = 2'd3; lsu_unsigned = 0;
      tick();
      idle_inputs();
      $display("priority: first write w_addr=%0d", w_addr);
      checks++; if (w_ena !== 1'b1 || w_addr !== 5'd3) begin
         failures++; $display("FAIL prio_first got=%0b/%0d exp=1/3", w_ena, w_addr); end
      tick();
      $display("priority: second write w_addr=%0d", w_addr);
      checks++; if (w_ena !== 1'b1 || w_addr !== 5'd4 || w_data !== 64'h44) begin
         failures++; $display("FAIL prio_second got=%0b/%0d/%0h exp=1/4/44", w_ena, w_addr, w_data); end
   endtask

   task automatic test_full_fifo();
      bit   found, acc;
      int   seen;
      logic [4:0] order [2];
      do_reset();
      alu_valid = 1; alu_wen = 1; alu_rd = 5'd7; alu_data = 64'd100;
      lsu_valid = 1; lsu_rd = 5'd10; lsu_data = 64'hA; lsu_size = 2'd3; lsu_unsigned = 1;
      tick(); alu_data++;
      #1;
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL full_one_entry_ready got=%0b exp=1", lsu_ready); end
      lsu_rd = 5'd11; lsu_data = 64'hB;
      tick(); alu_data++;
      lsu_rd = 5'd12; lsu_data = 64'hC;
      found = 0;
      for (int k = 0; k < 12 && !found; k++) begin
         #1;
         checks++; if (lsu_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low cyc=%0d got=%0b exp=0", k, lsu_ready); end
         acc = alu_ready;
         tick();
         if (w_ena && w_addr == 5'd10) found = 1;
         if (acc) alu_data++;
      end
      checks++; if (!found) begin failures++; $display("FAIL full_first_pop timeout got=none exp=w_addr 10"); end
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL full_ready_return got=%0b exp=1", lsu_ready); end
      $display("full fifo: first load written, lsu_ready=%0b", lsu_ready);
      tick();
      idle_inputs();
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (w_ena && seen < 2) begin order[seen] = w_addr; seen++; end
      end
      checks++; if (seen != 2 || order[0] !== 5'd11 || order[1] !== 5'd12) begin
         failures++; $display("FAIL full_drain_order got=%0d writes exp=11 then 12", seen); end
   endtask

   task automatic test_starve();
      int   low_cnt, low_at;
      bit   acc, prev_low;
      logic [63:0] held;
      do_reset();
      alu_valid = 1; alu_wen = 1; alu_rd = 5'd2; alu_data = 64'h200;
      lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 64'h99; lsu_size = 2'd3;
      tick(); alu_data++;
      lsu_valid = 0;
      low_cnt = 0; low_at = -1; prev_low = 0; held = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (!alu_ready) begin low_cnt++; if (low_at < 0) low_at = k; held = alu_data; end
         acc = alu_ready;
         tick();
         if (!acc) begin
            $display("starve: load write w_addr=%0d w_data=%0h", w_addr, w_data);
            checks++; if (w_addr !== 5'd9 || w_data !== 64'h99) begin
               failures++; $display("FAIL starve_load got=%0d/%0h exp=9/99", w_addr, w_data); end
         end else if (prev_low) begin
            checks++; if (w_ena !== 1'b1 || w_addr !== 5'd2 || w_data !== held) begin
               failures++; $display("FAIL starve_held_alu got=%0d/%0h exp=2/%0h", w_addr, w_data, held); end
         end
         prev_low = !acc;
         if (acc) alu_data++;
      end
      checks++; if (low_cnt != 1) begin failures++; $display("FAIL starve_low_cycles got=%0d exp=1", low_cnt); end
      checks++; if (low_at != 4) begin failures++; $display("FAIL starve_low_cycle_index got=%0d exp=4", low_at); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      int stray;
      do_reset();
      alu_valid = 1; alu_wen = 1; alu_rd = 5'd7; alu_data = 64'h70;
      lsu_valid = 1; lsu_rd = 5'd20; lsu_data = 64'h20; lsu_size = 2'd3;
      tick();
      lsu_rd = 5'd21; lsu_data = 64'h21;
      tick();
      lsu_valid = 0;
      tick();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      checks++; if (w_ena !== 1'b0) begin failures++; $display("FAIL rstmid_w_ena got=%0b exp=0", w_ena); end
      #1;
      checks++; if (lsu_ready !== 1'b1) begin failures++; $display("FAIL rstmid_lsu_ready got=%0b exp=1", lsu_ready); end
      stray = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (w_ena) stray++;
      end
      checks++; if (stray != 0) begin failures++; $display("FAIL rstmid_stray_writes got=%0d exp=0", stray); end
      $display("reset mid-operation: stray writes=%0d", stray);
   endtask

   task automatic test_random();
      bit hold_alu, hold_lsu;
      do_reset();
      mq.delete(); m_wait = 0;
      hold_alu = 0; hold_lsu = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         rst = ($urandom_range(0, 99) == 0);
         if (!hold_alu) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_wen   = ($urandom_range(0, 5) != 0);
            alu_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data  = {$urandom, $urandom};
         end
         if (!hold_lsu) begin
            lsu_valid    = ($urandom_range(0, 2) == 0);
            lsu_rd       = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            lsu_data     = {$urandom, $urandom};
            lsu_size     = 2'($urandom_range(0, 3));
            lsu_off      = 3'(($urandom_range(0, 7) >> lsu_size) << lsu_size);
            lsu_unsigned = 1'($urandom_range(0, 1));
         end
         #1;
         model_step();
         if (!rst) begin
            checks++; if (alu_ready !== m_alu_ready) begin
               failures++; $display("FAIL rand_alu_ready cyc=%0d got=%0b exp=%0b", cyc, alu_ready, m_alu_ready); end
            checks++; if (lsu_ready !== m_lsu_ready) begin
               failures++; $display("FAIL rand_lsu_ready cyc=%0d got=%0b exp=%0b", cyc, lsu_ready, m_lsu_ready); end
         end
`ifdef WB_FWD_EN
         checks++; if (fwd_valid !== m_w_ena || (m_w_ena && (fwd_addr !== m_w_addr || fwd_data !== m_w_data))) begin
            failures++; $display("FAIL rand_fwd cyc=%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h",
                                 cyc, fwd_valid, fwd_addr, fwd_data, m_w_ena, m_w_addr, m_w_data); end
`endif
         hold_alu = !rst && alu_valid && !m_alu_ready;
         hold_lsu = !rst && lsu_valid && !m_lsu_ready;
         tick();
         if (m_w_ena) $display("rand cyc=%0d write rd=%0d data=%016h", cyc, m_w_addr, m_w_data);
         checks++; if (w_ena !== m_w_ena || w_addr !== m_w_addr || w_data !== m_w_data) begin
            failures++; $display("FAIL rand_write cyc=%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h",
                                 cyc, w_ena, w_addr, w_data, m_w_ena, m_w_addr, m_w_data); end
      end
      rst = 0;
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      tick();
      test_reset();
      test_alu();
      test_load_ext();
      test_priority();
      test_full_fifo();
      test_starve();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
